bus_master_port: RTL and testbench

//  Initiator end of the serial system bus: converts a parallel read/write request into bit-serial

---
 rtl/bus_pkg.sv | 24 ++
 rtl/bus_shift_reg.sv | 48 ++++
 rtl/bus_master_port.sv | 288 ++++++++++++++++++++++++++++
 tb/tb_bus_master_port.sv | 312 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bus_pkg.sv
// Shared definitions for the serial system bus (bus_master_port and slave_port).
// Holds the default field widths, the watchdog limit and the master FSM state encoding.
package bus_pkg;

  localparam int unsigned BusAddrW  = 12;
  localparam int unsigned BusDataW  = 8;
  localparam int unsigned BusBurstW = 4;
  localparam int unsigned BusTmoCyc = 255;

  typedef enum logic [2:0] {
    StIdle,
    StAddr,
    StBurst,
    StWdata,
    StWack,
    StRdata,
    StRack
  } bus_state_e;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/bus_shift_reg.sv
// Shared PISO/SIPO shift register for the bus master.
// Ports:
//   clk, reset       clock, asynchronous active-low reset
//   load, load_val   parallel load (MSB is the first bit out)
//   shift, shift_in  shift left by one, shift_in enters at bit 0
//   ser_out          current serial bit (MSB)
//   par_out          low PW bits, i.e. the most recently shifted-in bits
// With load and shift together the loaded value is shifted once, so the first bit of a freshly
// loaded word can be consumed in the same cycle it is loaded.
module bus_shift_reg #(
  parameter int unsigned W  = 12,
  parameter int unsigned PW = 7
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          load,
  input  logic [W-1:0]  load_val,
  input  logic          shift,
  input  logic          shift_in,
  output logic          ser_out,
  output logic [PW-1:0] par_out
);

  logic [W-1:0] sr_q, sr_d;

  always_comb begin
    sr_d = sr_q;
    if (load && shift) begin
      sr_d = {load_val[W-2:0], shift_in};
    end else if (load) begin
      sr_d = load_val;
    end else if (shift) begin
      sr_d = {sr_q[W-2:0], shift_in};
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sr_q <= '0;
    end else begin
      sr_q <= sr_d;
    end
  end

  assign ser_out = sr_q[W-1];
  assign par_out = sr_q[PW-1:0];

endmodule

// File: rtl/bus_master_port.sv
// Initiator end of the serial system bus. Serializes address, burst length and write data
// MSB-first toward the slave, and deserializes read data coming back.
// Parallel side: req/wr/addr/burst/wdata in; wdata_req, rdata, rdata_valid, busy, done, error,
//   read_en, write_en out.
// Serial side: master_valid, master_ready, tx_address, tx_burst, tx_data, master_tx_done out;
//   slave_ready, slave_valid, rx_data, slave_rx_done, slave_tx_done in.
// Build option: BUS_MASTER_TIMEOUT_EN adds a watchdog that aborts a stalled transaction after
//   TMO_CYC cycles without progress (done and error pulse together). Without it error is 0.
module bus_master_port
  import bus_pkg::*;
#(
  parameter int unsigned ADDR_W  = BusAddrW,
  parameter int unsigned DATA_W  = BusDataW,
  parameter int unsigned BURST_W = BusBurstW
`ifdef BUS_MASTER_TIMEOUT_EN
  ,
  parameter int unsigned TMO_CYC = BusTmoCyc
`endif
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               req,
  input  logic               wr,
  input  logic [ADDR_W-1:0]  addr,
  input  logic [BURST_W-1:0] burst,
  input  logic [DATA_W-1:0]  wdata,
  output logic               wdata_req,
  output logic [DATA_W-1:0]  rdata,
  output logic               rdata_valid,
  output logic               busy,
  output logic               done,
  output logic               error,
  output logic               read_en,
  output logic               write_en,
  output logic               master_valid,
  output logic               master_ready,
  output logic               tx_address,
  output logic               tx_burst,
  output logic               tx_data,
  output logic               master_tx_done,
  input  logic               slave_ready,
  input  logic               slave_valid,
  input  logic               rx_data,
  input  logic               slave_rx_done,
  input  logic               slave_tx_done
);

  localparam int unsigned SrW  = max_u(ADDR_W, DATA_W);
  localparam int unsigned CntW = $clog2(SrW + 1);
  localparam logic [CntW-1:0] AddrLast  = CntW'(ADDR_W - 1);
  localparam logic [CntW-1:0] BurstLast = CntW'(BURST_W - 1);
  localparam logic [CntW-1:0] DataLast  = CntW'(DATA_W - 1);

  bus_state_e         state_q, state_d;
  logic               wr_q, wr_d;
  logic [BURST_W-1:0] burst_q, burst_d;
  logic [CntW-1:0]    bit_cnt_q, bit_cnt_d;
  logic [BURST_W-1:0] beat_cnt_q, beat_cnt_d;
  logic               need_load_q, need_load_d;  // next WDATA cycle starts a new beat
  logic               seen_q, seen_d;            // slave_tx_done seen during last read beat
  logic [DATA_W-1:0]  rdata_q, rdata_d;
  logic               rdata_valid_q, rdata_valid_d;
  logic               done_q, done_d;
  logic               error_d;
  logic               mtd_q, mtd_d;

  logic               sr_load, sr_shift, sr_shift_in, sr_ser;
  logic [SrW-1:0]     sr_load_val;
  logic [DATA_W-2:0]  sr_par;
  logic               xfer, rxfer;

  bus_shift_reg #(
    .W  (SrW),
    .PW (DATA_W - 1)
  ) u_shift_reg (
    .clk      (clk),
    .reset    (reset),
    .load     (sr_load),
    .load_val (sr_load_val),
    .shift    (sr_shift),
    .shift_in (sr_shift_in),
    .ser_out  (sr_ser),
    .par_out  (sr_par)
  );

  assign busy         = (state_q != StIdle);
  assign read_en      = busy & ~wr_q;
  assign write_en     = busy & wr_q;
  assign master_valid = (state_q == StAddr) | (state_q == StBurst) | (state_q == StWdata);
  assign master_ready = (state_q == StRdata);
  assign wdata_req    = (state_q == StWdata) & need_load_q;
  assign tx_address   = (state_q == StAddr) & sr_ser;
  assign tx_burst     = (state_q == StBurst) & sr_ser;
  // On a beat's load cycle the register is not yet filled, so drive the MSB straight from wdata.
  assign tx_data      = (state_q == StWdata) & (need_load_q ? wdata[DATA_W-1] : sr_ser);
  assign xfer         = master_valid & slave_ready;
  assign rxfer        = master_ready & slave_valid;

  assign rdata          = rdata_q;
  assign rdata_valid    = rdata_valid_q;
  assign done           = done_q;
  assign master_tx_done = mtd_q;

`ifdef BUS_MASTER_TIMEOUT_EN
  localparam int unsigned WdW = $clog2(TMO_CYC + 1);
  localparam logic [WdW-1:0] WdLast = WdW'(TMO_CYC - 1);
  logic [WdW-1:0] wdog_q, wdog_d;
  logic           error_q;
  logic           progress;
  assign error = error_q;
`else
  assign error = 1'b0;
`endif

  always_comb begin
    state_d       = state_q;
    wr_d          = wr_q;
    burst_d       = burst_q;
    bit_cnt_d     = bit_cnt_q;
    beat_cnt_d    = beat_cnt_q;
    need_load_d   = need_load_q;
    seen_d        = seen_q;
    rdata_d       = rdata_q;
    rdata_valid_d = 1'b0;
    done_d        = 1'b0;
    error_d       = 1'b0;
    mtd_d         = 1'b0;
    sr_load       = 1'b0;
    sr_shift      = 1'b0;
    sr_shift_in   = 1'b0;
    sr_load_val   = '0;

    unique case (state_q)
      StIdle: begin
        if (req) begin
          wr_d        = wr;
          burst_d     = burst;
          bit_cnt_d   = '0;
          beat_cnt_d  = '0;
          need_load_d = 1'b1;
          seen_d      = 1'b0;
          sr_load     = 1'b1;
          sr_load_val = SrW'(addr) << (SrW - ADDR_W);
          state_d     = StAddr;
        end
      end
      StAddr: begin
        if (xfer) begin
          if (bit_cnt_q == AddrLast) begin
            bit_cnt_d   = '0;
            sr_load     = 1'b1;
            sr_load_val = SrW'(burst_q) << (SrW - BURST_W);
            state_d     = StBurst;
          end else begin
            bit_cnt_d = bit_cnt_q + CntW'(1);
            sr_shift  = 1'b1;
          end
        end
      end
      StBurst: begin
        if (xfer) begin
          if (bit_cnt_q == BurstLast) begin
            bit_cnt_d = '0;
            state_d   = wr_q ? StWdata : StRdata;
          end else begin
            bit_cnt_d = bit_cnt_q + CntW'(1);
            sr_shift  = 1'b1;
          end
        end
      end
      StWdata: begin
        if (need_load_q) begin
          sr_load     = 1'b1;
          sr_load_val = SrW'(wdata) << (SrW - DATA_W);
          need_load_d = 1'b0;
        end
        if (xfer) begin
          if (bit_cnt_q == DataLast) begin
            bit_cnt_d = '0;
            if (beat_cnt_q == burst_q) begin
              mtd_d   = 1'b1;
              state_d = StWack;
            end else begin
              beat_cnt_d  = beat_cnt_q + BURST_W'(1);
              need_load_d = 1'b1;
            end
          end else begin
            bit_cnt_d = bit_cnt_q + CntW'(1);
            sr_shift  = 1'b1;
          end
        end
      end
      StWack: begin
        if (slave_rx_done) begin
          done_d  = 1'b1;
          state_d = StIdle;
        end
      end
      StRdata: begin
        if (slave_tx_done && (beat_cnt_q == burst_q)) begin
          seen_d = 1'b1;
        end
        if (rxfer) begin
          sr_shift    = 1'b1;
          sr_shift_in = rx_data;
          if (bit_cnt_q == DataLast) begin
            bit_cnt_d     = '0;
            rdata_d       = {sr_par, rx_data};
            rdata_valid_d = 1'b1;
            if (beat_cnt_q == burst_q) begin
              state_d = StRack;
            end else begin
              beat_cnt_d = beat_cnt_q + BURST_W'(1);
            end
          end else begin
            bit_cnt_d = bit_cnt_q + CntW'(1);
          end
        end
      end
      StRack: begin
        if (slave_tx_done || seen_q) begin
          done_d  = 1'b1;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

`ifdef BUS_MASTER_TIMEOUT_EN
    progress = xfer | rxfer | ((state_q == StWack) & slave_rx_done) |
               ((state_q == StRack) & (slave_tx_done | seen_q));
    wdog_d = '0;
    if ((state_q != StIdle) && !progress) begin
      if (wdog_q == WdLast) begin
        state_d = StIdle;
        done_d  = 1'b1;
        error_d = 1'b1;
      end else begin
        wdog_d = wdog_q + WdW'(1);
      end
    end
`endif
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= StIdle;
      wr_q          <= 1'b0;
      burst_q       <= '0;
      bit_cnt_q     <= '0;
      beat_cnt_q    <= '0;
      need_load_q   <= 1'b0;
      seen_q        <= 1'b0;
      rdata_q       <= '0;
      rdata_valid_q <= 1'b0;
      done_q        <= 1'b0;
      mtd_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      wr_q          <= wr_d;
      burst_q       <= burst_d;
      bit_cnt_q     <= bit_cnt_d;
      beat_cnt_q    <= beat_cnt_d;
      need_load_q   <= need_load_d;
      seen_q        <= seen_d;
      rdata_q       <= rdata_d;
      rdata_valid_q <= rdata_valid_d;
      done_q        <= done_d;
      mtd_q         <= mtd_d;
    end
  end

`ifdef BUS_MASTER_TIMEOUT_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wdog_q  <= '0;
      error_q <= 1'b0;
    end else begin
      wdog_q  <= wdog_d;
      error_q <= error_d;
    end
  end
`else
  logic unused_error_d;
  assign unused_error_d = error_d;
`endif

endmodule

// File: tb/tb_bus_master_port.sv
// Directed self-checking bench for bus_master_port (default widths 12/8/4).
module tb_bus_master_port;

  logic        clk = 1'b0;
  logic        reset;
  logic        req, wr;
  logic [11:0] addr;
  logic [3:0]  burst;
  logic [7:0]  wdata;
  logic        wdata_req;
  logic [7:0]  rdata;
  logic        rdata_valid, busy, done, error, read_en, write_en;
  logic        master_valid, master_ready, tx_address, tx_burst, tx_data, master_tx_done;
  logic        slave_ready, slave_valid, rx_data, slave_rx_done, slave_tx_done;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  bus_master_port dut (
    .clk            (clk),
    .reset          (reset),
    .req            (req),
    .wr             (wr),
    .addr           (addr),
    .burst          (burst),
    .wdata          (wdata),
    .wdata_req      (wdata_req),
    .rdata          (rdata),
    .rdata_valid    (rdata_valid),
    .busy           (busy),
    .done           (done),
    .error          (error),
    .read_en        (read_en),
    .write_en       (write_en),
    .master_valid   (master_valid),
    .master_ready   (master_ready),
    .tx_address     (tx_address),
    .tx_burst       (tx_burst),
    .tx_data        (tx_data),
    .master_tx_done (master_tx_done),
    .slave_ready    (slave_ready),
    .slave_valid    (slave_valid),
    .rx_data        (rx_data),
    .slave_rx_done  (slave_rx_done),
    .slave_tx_done  (slave_tx_done)
  );

  // Acts as the slave for one write. Starts in the caller's cycle (req accepted at next edge).
  // beats holds up to four bytes, first beat in [31:24].
  task automatic run_write(input logic [11:0] a, input logic [3:0] b, input logic [31:0] beats,
                           input bit toggle, input bit rxd_always, input bit busy_req,
                           output logic [11:0] ga, output logic [3:0] gb,
                           output logic [31:0] gd, output int n_wreq, output int n_mtd,
                           output int lat, output bit got_done, output bit got_err,
                           output bit busy_at_done, output int hold_viol);
    int  c, nbits, mtd_age;
    bit  prev_stall;
    logic prev_bit, cur;
    ga = '0; gb = '0; gd = '0; n_wreq = 0; n_mtd = 0; lat = 0; hold_viol = 0;
    got_done = 0; got_err = 0; busy_at_done = 0;
    c = 0; nbits = 0; mtd_age = -1; prev_stall = 0; prev_bit = 0;
    req = 1; wr = 1; addr = a; burst = b; slave_ready = 1; slave_rx_done = rxd_always;
    while (!got_done && c < 400) begin
      @(negedge clk);
      c++;
      if (busy_req) begin
        req = busy; wr = 0; addr = ~a; burst = 4'hF;
      end else begin
        req = 0;
      end
      if (toggle) slave_ready = ~slave_ready;
      if (wdata_req) begin
        if (n_wreq < 4) wdata = beats[31 - 8 * n_wreq -: 8];
        n_wreq++;
      end
      if (mtd_age >= 0) mtd_age++;
      if (mtd_age >= 2) slave_rx_done = 1;
      #1;
      if (master_tx_done) begin
        n_mtd++;
        if (mtd_age < 0) mtd_age = 0;
      end
      if (done) begin
        got_done = 1; got_err = error; busy_at_done = busy; lat = c;
      end
      if (master_valid) begin
        if (nbits < 12) cur = tx_address;
        else if (nbits < 16) cur = tx_burst;
        else cur = tx_data;
        if (prev_stall && cur !== prev_bit) hold_viol++;
        if (slave_ready) begin
          if (nbits < 12) ga = {ga[10:0], cur};
          else if (nbits < 16) gb = {gb[2:0], cur};
          else gd = {gd[30:0], cur};
          nbits++;
          prev_stall = 0;
        end else begin
          prev_stall = 1;
          prev_bit   = cur;
        end
      end
    end
    req = 0; slave_rx_done = 0; slave_ready = 1;
  endtask

  // Acts as the slave for one read; returns the rdata values seen, last in [7:0].
  task automatic run_read(input logic [11:0] a, input logic [3:0] b, input logic [31:0] bytes,
                          input bit early_txd, output logic [11:0] ga, output logic [3:0] gb,
                          output logic [31:0] gr, output int n_rv, output int lat,
                          output bit got_done, output bit got_err, output bit saw_re,
                          output bit saw_we);
    int c, nbits, idx, total;
    bit pulsed;
    ga = '0; gb = '0; gr = '0; n_rv = 0; lat = 0; got_done = 0; got_err = 0;
    saw_re = 0; saw_we = 0;
    c = 0; nbits = 0; idx = 0; total = 8 * (int'(b) + 1); pulsed = 0;
    req = 1; wr = 0; addr = a; burst = b; slave_ready = 1; slave_valid = 0; slave_tx_done = 0;
    while (!got_done && c < 400) begin
      @(negedge clk);
      c++;
      req = 0;
      slave_valid = (idx < total);
      rx_data = (idx < total) ? bytes[31 - idx] : 1'b0;
      if (early_txd) begin
        slave_tx_done = (idx == total - 4) && !pulsed;
        if (slave_tx_done) pulsed = 1;
      end else begin
        slave_tx_done = (idx >= total);
      end
      #1;
      if (c == 1) begin
        saw_re = read_en; saw_we = write_en;
      end
      if (master_valid && slave_ready) begin
        if (nbits < 12) ga = {ga[10:0], tx_address};
        else gb = {gb[2:0], tx_burst};
        nbits++;
      end
      if (master_ready && slave_valid) idx++;
      if (rdata_valid) begin
        gr = {gr[23:0], rdata};
        n_rv++;
      end
      if (done) begin
        got_done = 1; got_err = error; lat = c;
      end
    end
    slave_valid = 0; slave_tx_done = 0; rx_data = 0;
  endtask

  task automatic test_reset();
    logic [20:0] outs;
    repeat (2) @(negedge clk);
    #1;
    outs = {busy, done, error, read_en, write_en, master_valid, master_ready, tx_address,
            tx_burst, tx_data, master_tx_done, wdata_req, rdata_valid, rdata};
    n_checks++;
    if (outs !== '0) begin
      n_fail++; $display("FAIL reset_outputs: got %0h expected 0", outs);
    end
    @(negedge clk);
    reset = 1;
  endtask

  task automatic test_write_basic();
    logic [11:0] ga; logic [3:0] gb; logic [31:0] gd;
    int nw, nm, lat, hv; bit gdn, ger, bad;
    run_write(12'h123, 4'h0, 32'hA500_0000, 0, 0, 0, ga, gb, gd, nw, nm, lat, gdn, ger, bad, hv);
    n_checks++; if (ga !== 12'h123) begin n_fail++; $display("FAIL wr_addr: got %0h expected 123", ga); end
    n_checks++; if (gb !== 4'h0) begin n_fail++; $display("FAIL wr_burst: got %0h expected 0", gb); end
    n_checks++; if (gd[7:0] !== 8'hA5) begin n_fail++; $display("FAIL wr_data: got %0h expected a5", gd[7:0]); end
    n_checks++; if (nw != 1) begin n_fail++; $display("FAIL wr_wdata_req: got %0d expected 1", nw); end
    n_checks++; if (nm != 1) begin n_fail++; $display("FAIL wr_tx_done: got %0d expected 1", nm); end
    n_checks++; if (!gdn || ger) begin n_fail++; $display("FAIL wr_done: got done=%0d err=%0d expected 1/0", gdn, ger); end
    n_checks++; if (bad !== 1'b0) begin n_fail++; $display("FAIL wr_busy_at_done: got %0d expected 0", bad); end
    // 26-cycle minimum plus two cycles of slave_rx_done delay
    n_checks++; if (lat != 28) begin n_fail++; $display("FAIL wr_latency: got %0d expected 28", lat); end
  endtask

  task automatic test_read();
    logic [11:0] ga; logic [3:0] gb; logic [31:0] gr;
    int nrv, lat; bit gdn, ger, re, we;
    run_read(12'h0F0, 4'h2, 32'h1122_3300, 0, ga, gb, gr, nrv, lat, gdn, ger, re, we);
    n_checks++; if (ga !== 12'h0F0) begin n_fail++; $display("FAIL rd_addr: got %0h expected 0f0", ga); end
    n_checks++; if (gb !== 4'h2) begin n_fail++; $display("FAIL rd_burst: got %0h expected 2", gb); end
    n_checks++; if (nrv != 3) begin n_fail++; $display("FAIL rd_beats: got %0d expected 3", nrv); end
    n_checks++; if (gr[23:0] !== 24'h112233) begin n_fail++; $display("FAIL rd_data: got %0h expected 112233", gr[23:0]); end
    n_checks++; if (!re || we) begin n_fail++; $display("FAIL rd_enables: got re=%0d we=%0d expected 1/0", re, we); end
    n_checks++; if (!gdn || ger) begin n_fail++; $display("FAIL rd_done: got done=%0d err=%0d expected 1/0", gdn, ger); end
    n_checks++; if (lat != 42) begin n_fail++; $display("FAIL rd_latency: got %0d expected 42", lat); end
  endtask

  task automatic test_read_early_ack();
    logic [11:0] ga; logic [3:0] gb; logic [31:0] gr;
    int nrv, lat; bit gdn, ger, re, we;
    // slave_tx_done pulses once mid last beat and is low when RACK is reached
    run_read(12'h3C5, 4'h1, 32'hC37E_0000, 1, ga, gb, gr, nrv, lat, gdn, ger, re, we);
    n_checks++; if (gr[15:0] !== 16'hC37E || nrv != 2) begin n_fail++; $display("FAIL rd_early_data: got %0h/%0d expected c37e/2", gr[15:0], nrv); end
    n_checks++; if (!gdn || lat != 34) begin n_fail++; $display("FAIL rd_early_done: got done=%0d lat=%0d expected 1/34", gdn, lat); end
  endtask

  task automatic test_stall_write();
    logic [11:0] ga; logic [3:0] gb; logic [31:0] gd;
    int nw, nm, lat, hv; bit gdn, ger, bad;
    run_write(12'h5A3, 4'h3, 32'hDEAD_BEEF, 1, 0, 0, ga, gb, gd, nw, nm, lat, gdn, ger, bad, hv);
    n_checks++; if (ga !== 12'h5A3 || gb !== 4'h3) begin n_fail++; $display("FAIL stall_hdr: got %0h/%0h expected 5a3/3", ga, gb); end
    n_checks++; if (gd !== 32'hDEADBEEF) begin n_fail++; $display("FAIL stall_data: got %0h expected deadbeef", gd); end
    n_checks++; if (nw != 4) begin n_fail++; $display("FAIL stall_wdata_req: got %0d expected 4", nw); end
    n_checks++; if (hv != 0) begin n_fail++; $display("FAIL stall_hold: got %0d changes expected 0", hv); end
    n_checks++; if (!gdn) begin n_fail++; $display("FAIL stall_done: got 0 expected 1"); end
  endtask

  task automatic test_req_while_busy();
    logic [11:0] ga; logic [3:0] gb; logic [31:0] gd;
    int nw, nm, lat, hv; bit gdn, ger, bad;
    run_write(12'h123, 4'h0, 32'h5A00_0000, 0, 0, 1, ga, gb, gd, nw, nm, lat, gdn, ger, bad, hv);
    n_checks++; if (ga !== 12'h123 || gb !== 4'h0) begin n_fail++; $display("FAIL busyreq_hdr: got %0h/%0h expected 123/0", ga, gb); end
    n_checks++; if (gd[7:0] !== 8'h5A || nw != 1 || nm != 1) begin n_fail++; $display("FAIL busyreq_data: got %0h/%0d/%0d expected 5a/1/1", gd[7:0], nw, nm); end
    n_checks++; if (!gdn || lat != 28) begin n_fail++; $display("FAIL busyreq_done: got %0d/%0d expected 1/28", gdn, lat); end
    @(negedge clk); #1;
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL busyreq_idle: got busy=%0d expected 0", busy); end
  endtask

  task automatic test_back_to_back();
    logic [11:0] ga; logic [3:0] gb; logic [31:0] gd;
    int nw, nm, lat, hv; bit gdn, ger, bad;
    run_write(12'h0FF, 4'h1, 32'h8001_0000, 0, 1, 0, ga, gb, gd, nw, nm, lat, gdn, ger, bad, hv);
    n_checks++; if (gd[15:0] !== 16'h8001 || lat != 34) begin n_fail++; $display("FAIL b2b_first: got %0h lat %0d expected 8001 lat 34", gd[15:0], lat); end
    run_write(12'hF00, 4'h0, 32'h7F00_0000, 0, 1, 0, ga, gb, gd, nw, nm, lat, gdn, ger, bad, hv);
    n_checks++; if (ga !== 12'hF00 || gd[7:0] !== 8'h7F) begin n_fail++; $display("FAIL b2b_second: got %0h/%0h expected f00/7f", ga, gd[7:0]); end
    n_checks++; if (!gdn || lat != 26) begin n_fail++; $display("FAIL b2b_latency: got %0d/%0d expected 1/26", gdn, lat); end
  endtask

  task automatic test_reset_mid_addr();
    logic [11:0] ga; logic [3:0] gb; logic [31:0] gd;
    logic [20:0] outs;
    int nw, nm, lat, hv; bit gdn, ger, bad, saw_done;
    req = 1; wr = 1; addr = 12'h2D7; burst = 4'h0; wdata = 8'h00; slave_ready = 1;
    slave_rx_done = 0;
    for (int i = 1; i <= 6; i++) begin
      @(negedge clk);
      req = 0;
    end
    #1;
    // cycle 6 presents address bit index 5 (0x2D7 -> 0010_11...)
    n_checks++; if (!busy || tx_address !== 1'b1) begin n_fail++; $display("FAIL rst_mid_pre: got busy=%0d bit=%0d expected 1/1", busy, tx_address); end
    reset = 0;
    #1;
    outs = {busy, done, error, read_en, write_en, master_valid, master_ready, tx_address,
            tx_burst, tx_data, master_tx_done, wdata_req, rdata_valid, rdata};
    n_checks++; if (outs !== '0) begin n_fail++; $display("FAIL rst_mid_outputs: got %0h expected 0", outs); end
    saw_done = 0;
    repeat (3) begin
      @(negedge clk); #1;
      if (done) saw_done = 1;
    end
    @(negedge clk);
    reset = 1;
    #1;
    if (done) saw_done = 1;
    n_checks++; if (saw_done) begin n_fail++; $display("FAIL rst_mid_no_done: got done=1 expected 0"); end
    run_write(12'hABC, 4'h0, 32'h3C00_0000, 0, 0, 0, ga, gb, gd, nw, nm, lat, gdn, ger, bad, hv);
    n_checks++; if (ga !== 12'hABC || gd[7:0] !== 8'h3C || lat != 28) begin n_fail++; $display("FAIL rst_mid_restart: got %0h/%0h lat %0d expected abc/3c lat 28", ga, gd[7:0], lat); end
  endtask

  task automatic test_timeout();
    int c; bit got_done, got_err;
    req = 1; wr = 0; addr = 12'h001; burst = 4'h0; slave_ready = 1; slave_valid = 0;
    slave_tx_done = 0;
    c = 0; got_done = 0; got_err = 0;
    while (!got_done && c < 600) begin
      @(negedge clk);
      c++;
      req = 0;
      #1;
      if (done) begin
        got_done = 1; got_err = error;
      end
    end
`ifdef BUS_MASTER_TIMEOUT_EN
    n_checks++; if (!got_done || !got_err) begin n_fail++; $display("FAIL tmo_abort: got done=%0d err=%0d expected 1/1", got_done, got_err); end
    // 16 header transfers, 255 stalled cycles, then the done cycle
    n_checks++; if (c != 272) begin n_fail++; $display("FAIL tmo_cycles: got %0d expected 272", c); end
`else
    n_checks++; if (got_done || got_err) begin n_fail++; $display("FAIL tmo_none: got done=%0d err=%0d expected 0/0", got_done, got_err); end
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL tmo_busy: got %0d expected 1", busy); end
    @(negedge clk);
    reset = 0;
    @(negedge clk);
    reset = 1;
`endif
  endtask

  initial begin
    reset = 0; req = 0; wr = 0; addr = '0; burst = '0; wdata = '0;
    slave_ready = 0; slave_valid = 0; rx_data = 0; slave_rx_done = 0; slave_tx_done = 0;
    test_reset();
    test_write_basic();
    test_read();
    test_read_early_ack();
    test_stall_write();
    test_req_while_busy();
    test_back_to_back();
    test_reset_mid_addr();
    test_timeout();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
